// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo round-robin drain arbiter.
// Contents: FSM state encoding, the widest supported source count, and
// a one-hot decode helper.
package fifo_arb_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned MAX_SRC = 32;

  // ARB: scan eligible sources; READ: rd_en pulse out; CAPT: fifo dout valid;
  // VALID: word presented downstream
  typedef enum logic [STATE_W-1:0] {
    ST_ARB   = 2'd0,
    ST_READ  = 2'd1,
    ST_CAPT  = 2'd2,
    ST_VALID = 2'd3
  } arb_state_e;

  // One-hot decode of an index; the caller truncates to its source count
  function automatic logic [MAX_SRC-1:0] onehot_vec(input logic [31:0] idx);
    onehot_vec = MAX_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Ports: req   - request vector, one bit per source
//        ptr   - highest-priority index (must be < N)
//        gnt_idx - first requesting index at or after ptr, wrapping modulo N
//        any   - at least one request present
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  localparam int unsigned SW = PW + 1;

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [SW-1:0]  sum;

  // Rotate so that bit 0 is the ptr source, find lowest set bit, rotate back
  always_comb begin
    req2 = {req, req};
    rot  = N'(req2 >> ptr);
    off  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    any = |rot;
    // ptr and off are both < N, so one conditional subtract is enough
    sum = SW'(ptr) + SW'(off);
    if (sum >= SW'(N)) sum = sum - SW'(N);
    gnt_idx = PW'(sum);
  end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain controller: sole reader of NUM_SRC fifos, forwarding
// one word at a time to a ready/valid consumer tagged with its source.
// Ports: clk, rst (sync, active-high)
//        src_mask  - per-source eligibility
//        src_empty - per-source fifo empty flag
//        src_dout  - fifo i registered dout at [i*WIDTH +: WIDTH]
//        src_rd_en - registered one-hot-or-zero read pulse
//        out_data/out_src/out_valid/out_ready - downstream handshake
module fifo_rr_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_mask,
  input  logic [NUM_SRC-1:0]       src_empty,
  input  logic [NUM_SRC*WIDTH-1:0] src_dout,
  output logic [NUM_SRC-1:0]       src_rd_en,
  output logic [WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_SRC - 1);

  arb_state_e         state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0] rd_en_q, rd_en_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               out_valid_q, out_valid_d;

  logic [NUM_SRC-1:0] elig_c;
  logic [SRC_W-1:0]   grant_inc_c;
  logic [SRC_W-1:0]   scan_ptr_c;
  logic [SRC_W-1:0]   pick_idx_c;
  logic               pick_any_c;
  logic [WIDTH-1:0]   dout_arr [NUM_SRC];

  // Unpack the flat dout bus for indexing by grant
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_dout
    assign dout_arr[g] = src_dout[g*WIDTH +: WIDTH];
  end

  assign elig_c      = src_mask & ~src_empty;
  // Explicit wrap keeps the pointer in range for non-power-of-2 counts
  assign grant_inc_c = (grant_q == LAST_IDX) ? '0 : grant_q + SRC_W'(1);
  // On a handshake the re-arbitration already scans from the advanced pointer
  assign scan_ptr_c  = (state_q == ST_VALID) ? grant_inc_c : rr_ptr_q;

  rr_priority_picker #(
    .N  (NUM_SRC),
    .PW (SRC_W)
  ) u_picker (
    .req     (elig_c),
    .ptr     (scan_ptr_c),
    .gnt_idx (pick_idx_c),
    .any     (pick_any_c)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      rd_en_q     <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_en_q     <= rd_en_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    rd_en_d     = '0;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_ARB: begin
        if (pick_any_c) begin
          grant_d = pick_idx_c;
          rd_en_d = NUM_SRC'(onehot_vec(32'(pick_idx_c)));
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        out_data_d  = dout_arr[grant_q];
        out_src_d   = grant_q;
        out_valid_d = 1'b1;
        state_d     = ST_VALID;
      end
      ST_VALID: begin
        if (out_ready) begin
          rr_ptr_d    = grant_inc_c;
          out_valid_d = 1'b0;
          if (pick_any_c) begin
            grant_d = pick_idx_c;
            rd_en_d = NUM_SRC'(onehot_vec(32'(pick_idx_c)));
            state_d = ST_READ;
          end else begin
            state_d = ST_ARB;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign src_rd_en = rd_en_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Bench for fifo_rr_drain_arbiter: four 8-deep fifos with registered dout,
// a transaction-level reference model checked every cycle, directed
// scenarios and a randomized soak.
module tb_fifo_rr_drain_arbiter;

  localparam int NS = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] src_mask = 4'hF;
  logic [NS-1:0] src_empty;
  logic [NS*W-1:0] src_dout;
  logic [NS-1:0] src_rd_en;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src;
  logic          out_valid;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_rr_drain_arbiter #(.NUM_SRC(NS), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_mask  (src_mask),
    .src_empty (src_empty),
    .src_dout  (src_dout),
    .src_rd_en (src_rd_en),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Fifo models: 8 entries each, dout registered on rd_en
  logic [W-1:0] mem [NS][8];
  logic [W-1:0] fdout [NS];
  int wr_cnt [NS];
  int rd_cnt [NS];

  for (genvar g = 0; g < NS; g++) begin : g_fifo
    assign src_empty[g]          = (wr_cnt[g] == rd_cnt[g]);
    assign src_dout[g*W +: W]    = fdout[g];
    initial begin
      wr_cnt[g] = 0;
      rd_cnt[g] = 0;
      fdout[g]  = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (src_rd_en[i] && wr_cnt[i] != rd_cnt[i]) begin
        fdout[i]  <= mem[i][3'(rd_cnt[i])];
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one word in flight; rd_en issued the cycle after the
  // decision, word presented two cycles later until accepted
  bit         chk_en = 0;
  bit         m_busy = 0;
  int         m_c0   = 0;
  int         m_g    = 0;
  int         m_ptr  = 0;
  logic [7:0] m_d    = '0;

  logic [NS-1:0] prev_elig = '0;
  bit            prev_v = 0, prev_rdy = 0, prev_rst = 1;
  logic [7:0]    prev_data = '0;
  logic [1:0]    prev_src = '0;

  logic [7:0] lg_d [$];
  int         lg_s [$];
  int         lg_c [$];
  int         first_rd_cyc = -1;
  logic [3:0] first_rd_val = '0;
  int         rd_pulses = 0;

  always @(negedge clk) begin
    logic [3:0]    exp_rd;
    logic [NS-1:0] elig;
    bit            exp_v;
    bit            found;
    int            s;
    exp_v  = m_busy && (cyc >= m_c0 + 2);
    exp_rd = (m_busy && cyc == m_c0) ? 4'(1 << m_g) : 4'b0;
    if (chk_en) begin
      chk("rd_en", 32'(src_rd_en), 32'(exp_rd));
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("out_data", 32'(out_data), 32'(m_d));
        chk("out_src", 32'(out_src), 32'(m_g));
      end
      if (src_rd_en != 0) begin
        chk("rd_en_onehot0", 32'($onehot0(src_rd_en)), 32'(1));
        chk("rd_en_elig", 32'(src_rd_en & ~prev_elig), 32'(0));
        rd_pulses++;
        if (first_rd_cyc < 0) begin
          first_rd_cyc = cyc;
          first_rd_val = src_rd_en;
        end
      end
      if (prev_v && !prev_rdy && !prev_rst && out_valid) begin
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_src", 32'(out_src), 32'(prev_src));
      end
    end
    elig = src_mask & ~src_empty;
    if (rst) begin
      m_busy = 0;
      m_ptr  = 0;
      chk_en = 1;
    end else begin
      if (exp_v && out_ready) begin
        lg_d.push_back(out_data);
        lg_s.push_back(int'(out_src));
        lg_c.push_back(cyc);
        m_ptr  = (m_g + 1) % NS;
        m_busy = 0;
      end
      if (!m_busy && elig != 0) begin
        found = 0;
        for (int k = 0; k < NS; k++) begin
          s = (m_ptr + k) % NS;
          if (!found && elig[s]) begin
            found = 1;
            m_g   = s;
          end
        end
        m_busy = 1;
        m_c0   = cyc + 1;
        m_d    = mem[m_g][3'(rd_cnt[m_g])];
      end
    end
    prev_elig = elig;
    prev_v    = out_valid;
    prev_rdy  = out_ready;
    prev_rst  = rst;
    prev_data = out_data;
    prev_src  = out_src;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int s, input logic [7:0] v);
    if (wr_cnt[s] - rd_cnt[s] < 8) begin
      mem[s][3'(wr_cnt[s])] = v;
      wr_cnt[s] = wr_cnt[s] + 1;
    end
  endtask

  task automatic clear_log();
    lg_d.delete();
    lg_s.delete();
    lg_c.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (lg_s.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (lg_s.size() < n) chk({tag, "_timeout"}, 32'(lg_s.size()), 32'(n));
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k = 0;
    while (!out_valid && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_valid_seen"}, 32'(out_valid), 32'(1));
  endtask

  task automatic wait_rd(input int budget, input string tag);
    int k = 0;
    while (src_rd_en == 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_rd_seen"}, 32'(src_rd_en != 0), 32'(1));
  endtask

  task automatic chk_log(input string tag, input int idx, input int s, input logic [7:0] d);
    if (idx < lg_s.size()) begin
      chk({tag, "_src"}, 32'(lg_s[idx]), 32'(s));
      chk({tag, "_data"}, 32'(lg_d[idx]), 32'(d));
    end else begin
      chk({tag, "_missing"}, 32'(lg_s.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    // Reset with non-empty fifos
    tick(1);
    push(0, 8'hA0); push(0, 8'hA1); push(2, 8'hC0); push(3, 8'hD0);
    tick(1);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_src", 32'(out_src), 32'(0));
    chk("rst_rd_en", 32'(src_rd_en), 32'(0));
    clear_log();
    first_rd_cyc = -1;
    out_ready = 1'b1;
    rst = 1'b0;
    rel = cyc;

    // Round-robin order and spacing
    wait_log(4, 40, "rr");
    chk("rst_first_rd_delay", 32'(first_rd_cyc - rel), 32'(1));
    chk("rst_first_rd_src", 32'(first_rd_val), 32'(4'b0001));
    chk_log("rr0", 0, 0, 8'hA0);
    chk_log("rr1", 1, 2, 8'hC0);
    chk_log("rr2", 2, 3, 8'hD0);
    chk_log("rr3", 3, 0, 8'hA1);
    for (int i = 0; i < 3; i++)
      if (i + 1 < lg_c.size()) chk("rr_spacing", 32'(lg_c[i+1] - lg_c[i]), 32'(3));

    // Backpressure
    tick(2);
    clear_log();
    out_ready = 1'b0;
    push(1, 8'h5A);
    wait_valid(20, "bp");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_data", 32'(out_data), 32'(8'h5A));
      chk("bp_src", 32'(out_src), 32'(1));
      chk("bp_no_rd", 32'(src_rd_en), 32'(0));
    end
    out_ready = 1'b1;
    wait_log(1, 5, "bp");
    chk_log("bp_acc", 0, 1, 8'h5A);

    // Mask: only 1 and 3 eligible, then all
    tick(2);
    rst = 1'b1;
    src_mask = 4'b1010;
    tick(1);
    clear_log();
    for (int s = 0; s < NS; s++) begin
      push(s, 8'(16 * s + 1));
      push(s, 8'(16 * s + 2));
    end
    rst = 1'b0;
    wait_log(4, 60, "mask");
    chk_log("mask0", 0, 1, 8'h11);
    chk_log("mask1", 1, 3, 8'h31);
    chk_log("mask2", 2, 1, 8'h12);
    chk_log("mask3", 3, 3, 8'h32);
    chk("mask_src0_cnt", 32'(wr_cnt[0] - rd_cnt[0]), 32'(2));
    chk("mask_src2_cnt", 32'(wr_cnt[2] - rd_cnt[2]), 32'(2));
    clear_log();
    src_mask = 4'hF;
    wait_log(4, 60, "unmask");
    chk_log("unmask0", 0, 0, 8'h01);
    chk_log("unmask1", 1, 2, 8'h21);
    chk_log("unmask2", 2, 0, 8'h02);
    chk_log("unmask3", 3, 2, 8'h22);

    // Reset in CAPT: pointer was 3, afterwards scan restarts at 0
    tick(2);
    clear_log();
    out_ready = 1'b0;
    push(3, 8'hE3);
    push(0, 8'hE0);
    wait_rd(20, "rcapt");
    chk("rcapt_grant", 32'(src_rd_en), 32'(4'b1000));
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rcapt_valid", 32'(out_valid), 32'(0));
    chk("rcapt_rd_en", 32'(src_rd_en), 32'(0));
    chk("rcapt_data", 32'(out_data), 32'(0));
    out_ready = 1'b1;
    wait_log(1, 20, "rcapt");
    chk_log("rcapt_next", 0, 0, 8'hE0);

    // Reset in VALID
    tick(2);
    clear_log();
    out_ready = 1'b0;
    push(2, 8'hF2);
    push(3, 8'hF3);
    wait_valid(20, "rvalid");
    chk("rvalid_src", 32'(out_src), 32'(2));
    rst = 1'b1;
    push(0, 8'hF0);
    tick(1);
    rst = 1'b0;
    chk("rvalid_valid", 32'(out_valid), 32'(0));
    chk("rvalid_rd_en", 32'(src_rd_en), 32'(0));
    out_ready = 1'b1;
    wait_log(2, 30, "rvalid");
    chk_log("rvalid0", 0, 0, 8'hF0);
    chk_log("rvalid1", 1, 3, 8'hF3);

    // Wrap: bring pointer to 3, serve source 3, then 0 beats 3
    tick(2);
    clear_log();
    push(2, 8'h62);
    wait_log(1, 20, "wrap_a");
    tick(1);
    clear_log();
    push(3, 8'h63);
    wait_log(1, 20, "wrap_b");
    chk_log("wrap_b", 0, 3, 8'h63);
    tick(1);
    clear_log();
    push(0, 8'h60);
    push(3, 8'h73);
    wait_log(2, 30, "wrap_c");
    chk_log("wrap_c0", 0, 0, 8'h60);
    chk_log("wrap_c1", 1, 3, 8'h73);

    // Idle: everything empty
    tick(3);
    rd_pulses = 0;
    tick(20);
    chk("idle_rd_pulses", 32'(rd_pulses), 32'(0));
    chk("idle_valid", 32'(out_valid), 32'(0));

    // Randomized soak
    for (int i = 0; i < 1500; i++) begin
      tick(1);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) src_mask = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 5) == 0) push(s, 8'($urandom));
    end
    rst = 1'b0;
    src_mask = 4'hF;
    out_ready = 1'b1;
    tick(150);
    for (int s = 0; s < NS; s++) chk("drain_empty", 32'(src_empty[s]), 32'(1));
    chk("drain_valid", 32'(out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
